nem_ohmux_seq: RTL

Parametrised NEM-relay one-hot inverting mux with a break-before-make select sequencer. It generalises the fixed 4-input, 8-bit one-hot inverting mux cell to N_IN inputs of WIDTH bits each. It also adds a registered select path that honours relay mechanical release and actuation times, so two relays are never closed at once. It sits between the configuration/routing controller, which issues select requests, and the relay-based routing fabric.

---
 rtl/nem_ohmux_pkg.sv | 23 ++
 rtl/nem_ohmux_core.sv | 21 ++
 rtl/nem_ohmux_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/nem_ohmux_pkg.sv
// rtl/nem_ohmux_pkg.sv - shared types, helpers and parameter checks for the NEM one-hot mux
package nem_ohmux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BREAK = 2'd1,
    MAKE  = 2'd2
  } state_t;

  localparam int MAX_N_IN = 64;

  // Zero or exactly one bit set; callers zero-extend narrower select vectors.
  function automatic logic is_onehot0(input logic [MAX_N_IN-1:0] v);
    return (v & (v - {{(MAX_N_IN-1){1'b0}}, 1'b1})) == '0;
  endfunction

  function automatic bit params_ok(input int n_in, input int width,
                                   input int t_off, input int t_on);
    return (n_in >= 2) && (n_in <= MAX_N_IN) && (width >= 1) &&
           (t_off >= 1) && (t_on >= 1);
  endfunction

endpackage

// File: rtl/nem_ohmux_core.sv
// rtl/nem_ohmux_core.sv - parametrised AND-OR-INVERT datapath of the one-hot relay mux
module nem_ohmux_core #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8
) (
  input  logic [N_IN*WIDTH-1:0] din,
  input  logic [N_IN-1:0]       sel_active,
  output logic [WIDTH-1:0]      zn
);

  logic [WIDTH-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < N_IN; i++) begin
      acc = acc | (din[i*WIDTH +: WIDTH] & {WIDTH{sel_active[i]}});
    end
    zn = ~acc;
  end

endmodule

// File: rtl/nem_ohmux_seq.sv
// rtl/nem_ohmux_seq.sv - break-before-make relay select sequencer around the one-hot inverting mux; optional output hold via NEM_OHMUX_HOLD_EN
module nem_ohmux_seq
  import nem_ohmux_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8,
  parameter int T_OFF = 3,
  parameter int T_ON  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       sel_req,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  input  logic [N_IN*WIDTH-1:0] din,
  output logic [N_IN-1:0]       sel_active,
  output logic [WIDTH-1:0]      zn,
  output logic                  busy,
  output logic                  err
);

  localparam int T_MAX = (T_OFF > T_ON) ? T_OFF : T_ON;
  localparam int CW    = $clog2(T_MAX + 1);

  if (!params_ok(N_IN, WIDTH, T_OFF, T_ON)) begin : g_bad_params
    $error("nem_ohmux_seq: illegal N_IN/WIDTH/T_OFF/T_ON");
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [N_IN-1:0] pending, pending_nxt;
  logic [N_IN-1:0] sel_active_nxt;
  logic            err_nxt;
  logic [WIDTH-1:0] zn_raw;

  nem_ohmux_core #(
    .N_IN  (N_IN),
    .WIDTH (WIDTH)
  ) u_core (
    .din        (din),
    .sel_active (sel_active),
    .zn         (zn_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= '0;
      sel_active <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pending    <= pending_nxt;
      sel_active <= sel_active_nxt;
      err        <= err_nxt;
    end
  end

  // All relays open for T_OFF cycles before the new one closes, then T_ON to settle.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    pending_nxt    = pending;
    sel_active_nxt = sel_active;
    err_nxt        = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          if (!is_onehot0(MAX_N_IN'(sel_req))) begin
            err_nxt = 1'b1;
          end else if (sel_req != sel_active) begin
            pending_nxt    = sel_req;
            sel_active_nxt = '0;
            cnt_nxt        = CW'(T_OFF - 1);
            state_nxt      = BREAK;
          end
        end
      end
      BREAK: begin
        if (cnt == '0) begin
          if (pending == '0) begin
            state_nxt = IDLE;
          end else begin
            sel_active_nxt = pending;
            cnt_nxt        = CW'(T_ON - 1);
            state_nxt      = MAKE;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      MAKE: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef NEM_OHMUX_HOLD_EN
  logic [WIDTH-1:0] hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '1;
    end else if (state == IDLE) begin
      hold <= zn_raw;
    end
  end
`endif

  always_comb begin
    sel_ready = (state == IDLE) && !rst;
    busy      = (state != IDLE);
`ifdef NEM_OHMUX_HOLD_EN
    zn        = (state == IDLE) ? zn_raw : hold;
`else
    zn        = zn_raw;
`endif
  end

endmodule
